icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter NSETS, default 16, giving the number of direct-mapped frames (power of two, 2..256).
REQ-002 The block SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 The block SHALL have port imemaddr  input  32  datapath fetch byte address (word-aligned).
REQ-006 The block SHALL have port ihit  output  1  requested word valid on imemload this cycle.
REQ-007 The block SHALL have port imemload  output  32  instruction word returned to datapath.
REQ-008 The block SHALL have port iREN  output  1  read request to memory controller.
REQ-009 The block SHALL have port iaddr  output  32  memory read byte address.
REQ-010 The block SHALL have port iwait  input  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0.
REQ-011 The block SHALL have port iload  input  32  memory read data.

Function
REQ-012 Address split: byte offset [1:0] ignored, index = next log2(NSETS) bits, tag = remaining upper bits.
REQ-013 Each frame SHALL hold valid (1 bit), tag, and one 32-bit data word.
REQ-014 FSM states: IDLE, FETCH.
REQ-015 IDLE: ihit = imemREN & valid[index] & (tag match), combinational, same cycle; imemload = frame data on hit, else 0.
REQ-016 IDLE, imemREN=1 and miss: latch imemaddr into miss-address register; next state FETCH.
REQ-017 IDLE, imemREN=0: ihit=0, iREN=0, no state change.
REQ-018 FETCH: iREN=1, iaddr = latched miss address; ihit=0 regardless of imemaddr.
REQ-019 FETCH with iwait=0: write iload, latched tag, valid=1 into latched index at that edge; next state IDLE; ihit asserts the following cycle if imemREN still presents that address.
REQ-020 FETCH with iwait=1: remain in FETCH, hold iaddr stable, no frame write.
REQ-021 In IDLE, iREN=0 and iaddr=0.
REQ-022 A fill replaces the frame unconditionally (no write-back; instruction side is read-only).
REQ-023 imemREN dropping or imemaddr changing during FETCH SHALL NOT abort the fill; the latched address is completed.
REQ-024 Minimum miss latency: request cycle (IDLE) + 1 FETCH cycle with iwait=0 + hit cycle = ihit 2 cycles after first request.

Reset
REQ-025 RST=1 at a rising edge SHALL clear all valid bits, set state IDLE, clear miss-address register.
REQ-026 Outputs during/after reset: ihit=0, imemload=0, iREN=0, iaddr=0 from the cycle following the reset edge.
REQ-027 Reset during FETCH SHALL abandon the fill without writing any frame.
REQ-028 Tag/data arrays need not be reset.

Structure
REQ-029 word_t and the state enum (icache_state_t) SHALL come from cpu_types_pkg; ICACHE index/tag width constants SHALL be derived locally from NSETS.
REQ-030 No sub-module; frame storage is an internal array in the same module.

Verification
REQ-031 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> iREN=1, iaddr=0x40 for 4 cycles, then ihit=1, imemload=0x8C220004 next cycle.
REQ-032 Hit: repeat fetch of 0x40 -> ihit=1 same cycle, iREN stays 0.
REQ-033 Conflict: fetch 0x00000000 then 0x00000040 (NSETS=16, same index 0) -> second access misses, refills; re-fetch of 0x0 misses again.
REQ-034 Address change mid-fill: during FETCH for 0x80 switch imemaddr to 0x84 -> iaddr stays 0x80, frame for 0x80 written, then 0x84 misses.
REQ-035 Reset mid-fill: RST=1 in FETCH for 0xC0 -> iREN=0 next cycle, subsequent fetch of 0xC0 misses.
REQ-036 Idle: imemREN=0 with valid frame address present -> ihit=0, iREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the instruction-cache controller states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Instruction-cache signals: datapath fetch port and memory-controller read port.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // The cache side sees fetch requests and memory responses as inputs.
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    // The environment side: datapath plus memory controller.
    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache.
// A miss latches the fetch address and holds a memory read until iwait drops.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  logic      CLK,
    input  logic      RST,
    icache_if.slave   bus
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = 30 - IDX_W;

    logic [TAG_W-1:0] tag_mem  [NSETS];
    word_t            data_mem [NSETS];
    logic [NSETS-1:0] valid_reg;

    icache_state_t state_reg;
    word_t         miss_addr_reg;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             hit;
    logic             fill_en;
    logic             unused_addr_bits;

    assign req_idx  = bus.imemaddr[IDX_W+1:2];
    assign req_tag  = bus.imemaddr[31:IDX_W+2];
    assign miss_idx = miss_addr_reg[IDX_W+1:2];
    assign miss_tag = miss_addr_reg[31:IDX_W+2];

    assign unused_addr_bits = &{1'b0, bus.imemaddr[1:0], miss_addr_reg[1:0]};

    // Lookup only answers in IDLE; during a fill the datapath always sees a stall.
    assign hit = (state_reg == IDLE) && bus.imemREN && valid_reg[req_idx]
                 && (tag_mem[req_idx] == req_tag);

    // A reset in the same cycle as the memory response discards the fill.
    assign fill_en = (state_reg == FETCH) && !bus.iwait && !RST;

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data_mem[req_idx] : '0;
    assign bus.iREN     = (state_reg == FETCH);
    assign bus.iaddr    = (state_reg == FETCH) ? miss_addr_reg : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
            valid_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.imemREN && !hit) begin
                        miss_addr_reg <= bus.imemaddr;
                        state_reg     <= FETCH;
                    end
                end
                FETCH: begin
                    // The latched address is completed even if the request goes away.
                    if (!bus.iwait) begin
                        valid_reg[miss_idx] <= 1'b1;
                        state_reg           <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.iload;
        end
    end

endmodule
